// File: rtl/dcs_pkg.sv
// Shared constants, FSM encoding and code-model helpers for the DCS receive decoder.
package dcs_pkg;

  localparam int N_INFO   = 48;
  localparam int N_CODED  = 96;
  localparam int N_STATES = 8;
  localparam int METRIC_W = 8;
  localparam int CNT_W    = 6;

  localparam logic [METRIC_W-1:0] METRIC_MAX = 8'd255;
  localparam logic [CNT_W-1:0]    CNT_LAST   = 6'(N_INFO - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACS  = 2'd1,
    ST_SEL  = 2'd2,
    ST_DONE = 2'd3
  } dcs_state_e;

  // Encoder output {p1,p0} leaving state s={s2,s1,s0} on input bit b.
  function automatic logic [1:0] code_pair(input logic [2:0] s, input logic b);
    return {b ^ s[1] ^ s[0], b ^ s[2] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0] bm);
    logic [METRIC_W:0] sum;
    sum = {1'b0, a} + {{(METRIC_W-1){1'b0}}, bm};
    return sum[METRIC_W] ? METRIC_MAX : sum[METRIC_W-1:0];
  endfunction

endpackage

// File: rtl/dcs_deinterleaver.sv
// Combinational block deinterleaver: undoes the 12 x 4 pair interleave of a received block.
module dcs_deinterleaver
  import dcs_pkg::*;
(
  input  logic [N_CODED-1:0] rx_word,
  output logic [N_CODED-1:0] fec
);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    fec = '0;
    for (int j = 0; j < 12; j++) begin
      for (int m = 0; m < 4; m++) begin
        for (int t = 0; t < 2; t++) begin
          fec[88 - 8*j + 2*m + t] = rx_word[72 - 24*m + 2*j + t];
        end
      end
    end
  end

endmodule

// File: rtl/dcs_rx_decoder.sv
// Hard-decision Viterbi decoder for a 48-bit rate-1/2 block: one trellis step per cycle,
// register-exchange survivors, single-result handshake.
module dcs_rx_decoder
  import dcs_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_CODED-1:0]  rx_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_INFO-1:0]   data_out,
  output logic [METRIC_W-1:0] err_metric,
  output logic                busy
);

  dcs_state_e                             state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [N_CODED-1:0]                     fec_q, fec_d, fec_w;
  logic [N_STATES-1:0][METRIC_W-1:0]      metric_q, metric_d, acs_metric;
  logic [N_STATES-1:0][N_INFO-1:0]        surv_q, surv_d, acs_surv;
  logic [N_INFO-1:0]                      data_q, data_d;
  logic [METRIC_W-1:0]                    err_q, err_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   in_ready_q, in_ready_d;
  logic                                   busy_q, busy_d;

  logic [1:0]          rx_pair;
  logic [2:0]          n_idx, pred0, pred1;
  logic [1:0]          d0, d1;
  logic [METRIC_W-1:0] cand0, cand1;
  logic [2:0]          best_idx;
  logic [METRIC_W-1:0] best_metric;
  logic                accept, handshake;

  dcs_deinterleaver u_deint (
    .rx_word (rx_word),
    .fec     (fec_w)
  );

  assign accept    = in_valid && in_ready_q;
  assign handshake = out_valid_q && out_ready;

  // Add-compare-select for all states; the deinterleaved block is shifted so the
  // current pair always sits in the top two bits.
  always_comb begin
    acs_metric = '0;
    acs_surv   = '0;
    n_idx      = '0;
    pred0      = '0;
    pred1      = '0;
    d0         = '0;
    d1         = '0;
    cand0      = '0;
    cand1      = '0;
    rx_pair    = fec_q[N_CODED-1 -: 2];
    for (int n = 0; n < N_STATES; n++) begin
      n_idx = 3'(n);
      pred0 = {n_idx[1:0], 1'b0};
      pred1 = {n_idx[1:0], 1'b1};
      d0    = rx_pair ^ code_pair(pred0, n_idx[2]);
      d1    = rx_pair ^ code_pair(pred1, n_idx[2]);
      cand0 = sat_add(metric_q[pred0], {1'b0, d0[1]} + {1'b0, d0[0]});
      cand1 = sat_add(metric_q[pred1], {1'b0, d1[1]} + {1'b0, d1[0]});
      if (cand0 <= cand1) begin
        acs_metric[n] = cand0;
        acs_surv[n]   = surv_q[pred0];
      end else begin
        acs_metric[n] = cand1;
        acs_surv[n]   = surv_q[pred1];
      end
      acs_surv[n][N_INFO - 1 - int'(cnt_q)] = n_idx[2];
    end
  end

  // Strict less-than keeps the lowest state index on ties.
  always_comb begin
    best_idx    = '0;
    best_metric = metric_q[0];
    for (int i = 1; i < N_STATES; i++) begin
      if (metric_q[i] < best_metric) begin
        best_idx    = 3'(i);
        best_metric = metric_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fec_d    = fec_q;
    metric_d = metric_q;
    surv_d   = surv_q;
    data_d   = data_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACS;
          cnt_d   = '0;
          fec_d   = fec_w;
          surv_d  = '0;
          for (int i = 0; i < N_STATES; i++) begin
            metric_d[i] = (i == 0) ? '0 : METRIC_MAX;
          end
        end
      end
      ST_ACS: begin
        metric_d = acs_metric;
        surv_d   = acs_surv;
        fec_d    = fec_q << 2;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SEL;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_SEL: begin
        data_d  = surv_q[best_idx];
        err_d   = best_metric;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (handshake) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // out_valid is a register behind DONE, giving the extra cycle of latency.
    out_valid_d = (state_q == ST_DONE) && !handshake;
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: path metrics and survivors are reset with everything else so an aborted
  // block leaves no stale trellis state behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fec_q       <= '0;
      metric_q    <= '0;
      surv_q      <= '0;
      data_q      <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fec_q       <= fec_d;
      metric_q    <= metric_d;
      surv_q      <= surv_d;
      data_q      <= data_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign err_metric = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dcs_rx_decoder.sv
// Directed bench for dcs_rx_decoder: golden encoder/interleaver builds the received blocks,
// expected decodes and metrics are fixed constants.
module tb_dcs_rx_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] rx_word;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] data_out;
  logic [7:0]  err_metric;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] INFO_A = 48'hA5A5_5A5A_C3C3;

  dcs_rx_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rx_word    (rx_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .err_metric (err_metric),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rate-1/2 encoder followed by the block interleaver.
  function automatic logic [95:0] encode_block(input logic [47:0] info);
    logic [95:0] fec;
    logic [95:0] rx;
    logic [2:0]  s;
    logic        b;
    fec = '0;
    rx  = '0;
    s   = '0;
    for (int k = 0; k < 48; k++) begin
      b = info[47-k];
      fec[95-2*k] = b ^ s[1] ^ s[0];
      fec[94-2*k] = b ^ s[2] ^ s[1] ^ s[0];
      s = {b, s[2], s[1]};
    end
    for (int j = 0; j < 12; j++)
      for (int m = 0; m < 4; m++)
        for (int t = 0; t < 2; t++)
          rx[72 - 24*m + 2*j + t] = fec[88 - 8*j + 2*m + t];
    return rx;
  endfunction

  task automatic accept_word(input string tag, input logic [95:0] w);
    @(negedge clk);
    check({tag, "_in_ready_pre"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    rx_word  = w;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_in_ready_post"}, 64'(in_ready), 64'd0);
    check({tag, "_busy_post"}, 64'(busy), 64'd1);
  endtask

  // Waits (bounded) for out_valid; latency counted in edges after the accept edge.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd50);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_busy_clear"}, 64'(busy), 64'd0);
  endtask

  task automatic run_block(input string tag, input logic [95:0] w,
                           input logic [47:0] exp_data, input logic [7:0] exp_err);
    accept_word(tag, w);
    wait_result(tag);
    check({tag, "_data"}, 64'(data_out), 64'(exp_data));
    check({tag, "_err"}, 64'(err_metric), 64'(exp_err));
    release_result(tag);
  endtask

  initial begin
    logic [95:0] word_a;
    logic [95:0] one;
    logic [95:0] w;
    int          seen;

    one       = 96'd1;
    word_a    = encode_block(INFO_A);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rx_word   = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_err", 64'(err_metric), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_block("zero", 96'h0, 48'h0, 8'd0);
    run_block("clean", word_a, INFO_A, 8'd0);
    run_block("flip50", word_a ^ (one << 50), INFO_A, 8'd1);

    // Two-error block, with the result held back for 20 cycles while new words are offered.
    w = word_a ^ (one << 3) ^ (one << 90);
    accept_word("flip3_90", w);
    wait_result("flip3_90");
    in_valid = 1'b1;
    rx_word  = 96'hFFFF_0000_FFFF_0000_FFFF_0000;
    for (int i = 0; i < 20; i++) begin
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(data_out), 64'(INFO_A));
      check("hold_err", 64'(err_metric), 64'd2);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    release_result("flip3_90");

    // Abort a block mid-trellis; it must never produce a result.
    accept_word("abort", word_a);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    check("abort_no_out_valid", 64'(seen), 64'd0);

    run_block("after_abort", word_a, INFO_A, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
